uart: RTL and testbench
=======================

Name: uart

Overview:
- Transmit-only asynchronous serial (UART) block: 8 data bits, no parity, 1 stop bit (8N1), LSB first, line idle high.
- Serialises one byte per request onto a single output pin.
- Emits a one-cycle completion pulse.
- Drives the TX line of packet-level senders (e.g. the Dynamixel sync-write framer), which chain bytes by issuing the next request right after each completion pulse.

Parameters:
- clocks_per_bit, default 1: clock cycles per serial bit (clock_freq / baud); legal range >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- send  input  1  transmit request; sampled on rising edge; normally a one-cycle pulse.
- byte_to_send  input  8  data byte; captured in the cycle send is accepted.
- done  output  1  one-cycle pulse: frame fully transmitted, ready for the next byte.
- pin  output  1  serial TX line, registered.

Behaviour:
- Reset (async assert, sync release): pin=1, done=0, state IDLE, bit counter=0, shift register=0.
- States: IDLE, START, DATA (bits 0..7), STOP.
- Each of START, each DATA bit, and STOP holds pin for exactly clocks_per_bit cycles.
- Counter width is max(1, $clog2(clocks_per_bit)). It wraps to 0 at clocks_per_bit-1.
- IDLE, send=1 at edge E:
  - latch byte_to_send;
  - pin=0 from E onward;
  - go to START.
- START -> DATA after clocks_per_bit cycles. pin = byte[0], then byte[1] ... byte[7], each held clocks_per_bit cycles.
- DATA -> STOP after bit 7. pin=1 for clocks_per_bit cycles.
- End of STOP (last counter value):
  - return to IDLE;
  - done=1 for exactly the following cycle, then 0;
  - pin stays 1.
- done never asserts during reset, in IDLE without a completed frame, or twice per frame.
- Frame length is 10*clocks_per_bit cycles from the accepting edge to the edge raising done.
- send while not IDLE (including the cycle done is high): ignored. byte_to_send changes mid-frame: no effect.
- Back-to-back: send asserted in the cycle after done is accepted, giving a minimum one extra idle-high cycle between frames.
- clocks_per_bit=1: one cycle per bit; must work with no off-by-one.
- Reset mid-frame: pin returns high immediately, frame is abandoned, no done pulse.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: insert an even-parity bit (XOR of the 8 data bits) between bit 7 and STOP, held clocks_per_bit cycles. Frame length becomes 11*clocks_per_bit.
- Undefined: plain 8N1 as above; no parity logic synthesised.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8 constant.
- Single module, no sub-modules. The bit-period counter is inline.

Test Plan:
- clocks_per_bit=4, send pulse with 0x55:
  - pin = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles;
  - done high one cycle, 40 cycles after the accepting edge.
- clocks_per_bit=1, byte 0xFF: pin low 1 cycle then high 9 cycles; done pulses once, 10 cycles after accept.
- Chained 0xFF,0xFF,0xFD,0x00 with send issued the cycle after each done:
  - four correct frames decoded LSB-first;
  - exactly four done pulses;
  - at least one idle-high cycle between frames.
- send pulsed with 0x00 mid-frame of 0xA5: second request ignored; only 0xA5 decoded; one done pulse.
- reset_n asserted during DATA of 0x3C: pin=1 immediately, no done; next send of 0x81 transmits correctly.
- UART_PARITY_EN defined, clocks_per_bit=2, byte 0x07: parity bit 1 between bit 7 and stop; done after 22 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the transmit-only 8N1 UART.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart.sv
// Transmit-only UART: 8 data bits, LSB first, 1 stop bit, line idle high.
// Define UART_PARITY_EN to insert an even-parity bit between bit 7 and STOP.
module uart
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] byte_to_send,
    output logic       done,
    output logic       pin
);

    localparam int CNT_W = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clocks_per_bit - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [7:0]     shift_q;
    logic           pin_q;
    logic           done_q;
`ifdef UART_PARITY_EN
    logic           parity_q;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    // NOTE: every state register updates with <= so all of them see the
    // pre-edge values of each other within this block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            pin_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            cnt_q  <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    // The cycle done is high counts as busy, so a request there is dropped.
                    if (send && !done_q) begin
                        state_q <= START;
                        pin_q   <= 1'b0;
                        shift_q <= byte_to_send;
`ifdef UART_PARITY_EN
                        parity_q <= ^byte_to_send;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        pin_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            state_q <= PARITY;
                            pin_q   <= parity_q;
`else
                            state_q <= STOP;
                            pin_q   <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            pin_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        pin_q   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pin_q   <= 1'b1;
                end
            endcase
        end
    end

    assign pin  = pin_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart.sv
// Directed testbench for uart: three instances at clocks_per_bit 4, 1 and 2.
module tb_uart;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int CPB_TAB [3] = '{4, 1, 2};

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] send_v = '0;
    logic [7:0] data_v [3];
    logic [2:0] done_v;
    logic [2:0] pin_v;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart #(.clocks_per_bit(CPB_TAB[g])) u_dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .send        (send_v[g]),
            .byte_to_send(data_v[g]),
            .done        (done_v[g]),
            .pin         (pin_v[g])
        );
    end

    // Expected line level during bit slot j of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge after the done cycle.
    task automatic tx_frame(input int idx, input logic [7:0] b, input int inject_at, input string name);
        int cpb = CPB_TAB[idx];
        int n = FRAME_BITS * cpb;
        int bad_pin = 0;
        int first_bad = -1;
        int bad_done = 0;
        logic [7:0] dec = '0;
        send_v[idx] = 1'b1;
        data_v[idx] = b;
        @(negedge clock);
        send_v[idx] = 1'b0;
        data_v[idx] = ~b;
        for (int k = 1; k <= n; k++) begin
            int j = (k - 1) / cpb;
            if (pin_v[idx] !== exp_bit(b, j)) begin
                bad_pin++;
                if (first_bad < 0) first_bad = k;
            end
            if (done_v[idx] !== 1'b0) bad_done++;
            if (j >= 1 && j <= 8 && ((k - 1) % cpb) == cpb / 2) dec[j-1] = pin_v[idx];
            send_v[idx] = (k == inject_at);
            data_v[idx] = (k == inject_at) ? 8'h00 : ~b;
            @(negedge clock);
        end
        vectors++;
        if (bad_pin != 0) begin
            miscompares++;
            $display("FAIL %s pin_trace: %0d bad cycles, first at cycle %0d; required frame of byte %02h",
                     name, bad_pin, first_bad, b);
        end
        vectors++;
        if (dec !== b) begin
            miscompares++;
            $display("FAIL %s decode: got %02h, required %02h", name, dec, b);
        end
        vectors++;
        if (bad_done != 0 || done_v[idx] !== 1'b1 || pin_v[idx] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timing: early=%0d done@%0d=%b pin=%b, required early=0 done=1 pin=1",
                     name, bad_done, n + 1, done_v[idx], pin_v[idx]);
        end
        @(negedge clock);
        vectors++;
        if (done_v[idx] !== 1'b0 || pin_v[idx] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_width: done=%b pin=%b, required done=0 pin=1",
                     name, done_v[idx], pin_v[idx]);
        end
    endtask

    task automatic idle_check(input int idx, input int n, input string name);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (pin_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) bad++;
            @(negedge clock);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s idle: %0d cycles not idle-high/no-done, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (pin_v !== 3'b111 || done_v !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: pin=%b done=%b, required pin=111 done=000", pin_v, done_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_check(i, 2, "post_reset");
    endtask

    task automatic test_cpb4();
        tx_frame(0, 8'h55, 0, "cpb4_55");
        idle_check(0, 5, "cpb4_after");
    endtask

    task automatic test_cpb1();
        tx_frame(1, 8'hFF, 0, "cpb1_FF");
        idle_check(1, 3, "cpb1_gap");
        tx_frame(1, 8'h6A, 0, "cpb1_6A");
        idle_check(1, 5, "cpb1_after");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'hFF, 8'hFF, 8'hFD, 8'h00};
        for (int i = 0; i < 4; i++) tx_frame(1, seq[i], 0, $sformatf("chain%0d", i));
        idle_check(1, 15, "chain_tail");
        for (int i = 0; i < 2; i++) tx_frame(0, seq[i+2], 0, $sformatf("chain4_%0d", i));
        idle_check(0, 10, "chain4_tail");
    endtask

    task automatic test_mid_frame_send();
        tx_frame(0, 8'hA5, 15, "ignore_A5");
        idle_check(0, 50, "ignore_tail");
    endtask

    task automatic test_reset_mid_frame();
        send_v[0] = 1'b1;
        data_v[0] = 8'h3C;
        @(negedge clock);
        send_v[0] = 1'b0;
        repeat (5) @(negedge clock);
        vectors++;
        if (pin_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_bit0: pin=%b, required 0", pin_v[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (pin_v !== 3'b111 || done_v !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_reset: pin=%b done=%b, required pin=111 done=000", pin_v, done_v);
        end
        @(negedge clock);
        reset_n = 1'b1;
        idle_check(0, 50, "abort_tail");
        tx_frame(0, 8'h81, 0, "after_abort_81");
    endtask

    task automatic test_parity();
`ifdef UART_PARITY_EN
        tx_frame(2, 8'h07, 0, "parity_cpb2_07");
`else
        tx_frame(2, 8'h07, 0, "cpb2_07");
`endif
        idle_check(2, 5, "cpb2_after");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;
        test_reset();
        test_cpb4();
        test_cpb1();
        test_back_to_back();
        test_mid_frame_send();
        test_reset_mid_frame();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
